dmem_responder: RTL and testbench

Memory-side responder for the data cache's refill/write interface: accepts one request at a time from the DCache miss/write path, waits a programmable latency, then returns a full cache line (critical word first) or a write acknowledge. Sits below the DCache in the MEM stage and backs it with an on-chip word-addressed RAM. The DCache's stall logic depends on this block's handshake timing.

---
 rtl/dmem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for the DCache refill/write path: one request at a time, programmable
// latency, critical-word-first line reads. Optional beat backpressure via `define RESP_READY_EN.
module dmem_responder #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_last,
    output logic        wack
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT = 4'(LATENCY);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RBURST = 2'd2,
        ST_WACK   = 2'd3
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]           mem_r [DEPTH];
    state_t                state_r;
    state_t                next_state_s;
    logic [3:0]            cnt_r;
    logic [3:0]            next_cnt_s;
    logic                  wr_r;
    logic [ADDR_WIDTH-1:0] word_r;
    logic [31:0]           wdata_r;
    logic [3:0]            wstrb_r;
    logic [OFF_W-1:0]      beat_r;
    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic [31:0]           resp_data_r;
    logic                  resp_last_r;
    logic                  wack_r;

    logic                  accept_s;
    logic                  xfer_s;
    logic                  start_burst_s;
    logic                  adv_beat_s;
    logic                  do_write_s;
    logic                  wr_sel_s;
    logic [ADDR_WIDTH-1:0] word_sel_s;
    logic [31:0]           wdata_sel_s;
    logic [3:0]            wstrb_sel_s;
    logic [OFF_W-1:0]      rd_beat_s;
    logic [ADDR_WIDTH-1:0] rd_idx_s;
    logic                  unused_s;

    assign accept_s = (state_r == ST_IDLE) && req_valid && req_ready_r;

`ifdef RESP_READY_EN
    assign xfer_s   = resp_ready;
    assign unused_s = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
`else
    assign xfer_s   = 1'b1;
    assign unused_s = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0], resp_ready};
`endif

    // With zero latency the request is served straight from the bus, otherwise from the capture.
    assign wr_sel_s    = (state_r == ST_IDLE) ? req_wr : wr_r;
    assign word_sel_s  = (state_r == ST_IDLE) ? req_addr[ADDR_WIDTH+1:2] : word_r;
    assign wdata_sel_s = (state_r == ST_IDLE) ? req_wdata : wdata_r;
    assign wstrb_sel_s = (state_r == ST_IDLE) ? req_wstrb : wstrb_r;

    // Beats wrap within the line: only the in-line offset advances.
    assign rd_beat_s = start_burst_s ? {OFF_W{1'b0}} : (beat_r + OFF_W'(1));
    assign rd_idx_s  = {word_sel_s[ADDR_WIDTH-1:OFF_W], word_sel_s[OFF_W-1:0] + rd_beat_s};

    // Next-state and transfer decode.
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_r;
        start_burst_s = 1'b0;
        adv_beat_s    = 1'b0;
        do_write_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 0) begin
                        if (req_wr) begin
                            next_state_s = ST_WACK;
                            do_write_s   = 1'b1;
                        end else begin
                            next_state_s  = ST_RBURST;
                            start_burst_s = 1'b1;
                        end
                    end else begin
                        next_state_s = ST_WAIT;
                        next_cnt_s   = LAT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                next_cnt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    next_cnt_s = 4'd0;
                    if (wr_sel_s) begin
                        next_state_s = ST_WACK;
                        do_write_s   = 1'b1;
                    end else begin
                        next_state_s  = ST_RBURST;
                        start_burst_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RBURST: begin
                if (xfer_s) begin
                    if (beat_r == LAST_BEAT) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        adv_beat_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_RBURST;
                end
            end
            ST_WACK: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
                next_cnt_s   = 4'd0;
            end
        endcase
    end

    // State, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            wr_r         <= 1'b0;
            word_r       <= {ADDR_WIDTH{1'b0}};
            wdata_r      <= 32'd0;
            wstrb_r      <= 4'd0;
            beat_r       <= {OFF_W{1'b0}};
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'd0;
            resp_last_r  <= 1'b0;
            wack_r       <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= next_cnt_s;
            req_ready_r <= (next_state_s == ST_IDLE);
            wack_r      <= do_write_s;
            if (accept_s) begin
                wr_r    <= req_wr;
                word_r  <= req_addr[ADDR_WIDTH+1:2];
                wdata_r <= req_wdata;
                wstrb_r <= req_wstrb;
            end
            if (start_burst_s || adv_beat_s) begin
                beat_r       <= rd_beat_s;
                resp_valid_r <= 1'b1;
                resp_data_r  <= mem_r[rd_idx_s];
                resp_last_r  <= (rd_beat_s == LAST_BEAT);
            end else if ((state_r == ST_RBURST) && xfer_s) begin
                resp_valid_r <= 1'b0;
                resp_data_r  <= 32'd0;
                resp_last_r  <= 1'b0;
            end
        end
    end

    // Byte-masked RAM write, committed on the same edge that raises wack.
    always_ff @(posedge clk) begin
        if (!rst && do_write_s) begin
            mem_r[word_sel_s] <= merge_bytes(mem_r[word_sel_s], wdata_sel_s, wstrb_sel_s);
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_last  = resp_last_r;
    assign wack       = wack_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: expected beats are queued at request time
// from a byte-level memory model and popped as the DUT transfers them.
module tb_dmem_responder;

    localparam int LW  = 4;
    localparam int AW  = 12;
    localparam int LAT = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        wack;

    logic [31:0] model [1 << AW];
    beat_t       sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    dmem_responder #(.LINE_WORDS(LW), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .wack       (wack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) in IDLE for req_ready, sampling on the falling edge.
    task automatic wait_ready();
        @(negedge clk);
        for (int i = 0; i < 40 && req_ready !== 1'b1; i++) @(negedge clk);
        check("req_ready_wait", req_ready, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int wk;
        logic [AW-1:0] idx;
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = data; req_wstrb = strb;
        @(posedge clk);
        idx = addr[AW+1:2];
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        wk = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(negedge clk);
            if (k == 1) begin req_valid = 1'b0; req_wr = 1'b0; end
            if (wack === 1'b1) begin wk = k; break; end
        end
        check("wack_cycle", 32'(wk), 32'(LAT + 1));
        @(negedge clk);
        check("wack_one_cycle", wack, 1'b0);
        check("ready_after_wack", req_ready, 1'b1);
    endtask

    // Read one line; optionally stall the second beat or pull reset after rst_after beats.
    task automatic do_read(input logic [31:0] addr, input bit stall, input int rst_after);
        int idx, first, vcyc, done, stall_left;
        bit xfer, prev_noxfer;
        logic [31:0] prev_data;
        beat_t e;
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; req_wdata = 32'd0; req_wstrb = 4'd0;
        @(posedge clk);
        idx = int'(addr[AW+1:2]);
        for (int b = 0; b < LW; b++) begin
            e.data = model[(idx & ~(LW - 1)) | ((idx + b) % LW)];
            e.last = (b == LW - 1);
            sb_q.push_back(e);
        end
        first = -1; vcyc = 0; done = 0; stall_left = 0; prev_noxfer = 1'b0; prev_data = 32'd0;
        for (int k = 1; k <= LAT + LW + 20; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (resp_valid === 1'b1) begin
                vcyc++;
                if (first < 0) begin
                    first = k;
                    check("ready_low_busy", req_ready, 1'b0);
                end
            end
`ifdef RESP_READY_EN
            xfer = (resp_valid === 1'b1) && (resp_ready === 1'b1);
`else
            xfer = (resp_valid === 1'b1);
`endif
            if (resp_valid === 1'b1 && prev_noxfer) check("hold_data", resp_data, prev_data);
            if (xfer) begin
                e = sb_q.pop_front();
                check("beat_data", resp_data, e.data);
                check("beat_last", resp_last, e.last);
                done++;
            end
            prev_noxfer = (resp_valid === 1'b1) && !xfer;
            prev_data   = resp_data;
            if (rst_after > 0 && done == rst_after) begin
                rst = 1'b1;
                break;
            end
            if (stall && xfer && done == 1) stall_left = 2;
            else if (stall_left > 0 && resp_valid === 1'b1 && resp_ready === 1'b0) stall_left--;
            resp_ready = (stall_left == 0);
            if (done == LW) break;
        end
        resp_ready = 1'b1;
        if (rst_after > 0) begin
            check("beats_before_rst", 32'(done), 32'(rst_after));
            @(negedge clk);
            check("rst_resp_valid", resp_valid, 1'b0);
            check("rst_resp_last", resp_last, 1'b0);
            check("rst_resp_data", resp_data, 32'd0);
            check("rst_req_ready", req_ready, 1'b0);
            rst = 1'b0;
            sb_q.delete();
            @(negedge clk);
            check("post_rst_ready", req_ready, 1'b1);
            check("post_rst_valid", resp_valid, 1'b0);
        end else begin
            check("beats_done", 32'(done), 32'(LW));
            check("first_beat_cycle", 32'(first), 32'(LAT + 1));
`ifdef RESP_READY_EN
            check("burst_cycles", 32'(vcyc), 32'(LW + (stall ? 2 : 0)));
`else
            check("burst_cycles", 32'(vcyc), 32'(LW));
`endif
            @(negedge clk);
            check("ready_after_last", req_ready, 1'b1);
            check("valid_after_last", resp_valid, 1'b0);
            check("last_after_last", resp_last, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_wstrb = 4'd0; resp_ready = 1'b1;
        @(negedge clk);
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_resp_last", resp_last, 1'b0);
        check("reset_resp_data", resp_data, 32'd0);
        check("reset_wack", wack, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1'b1);

        // Preload RAM[i] = i for the first four lines, then RAM[8] = 0x11223344.
        for (int i = 0; i < 16; i++) do_write(32'(i * 4), 32'(i), 4'hF);
        do_write(32'h0000_0020, 32'h1122_3344, 4'hF);

        do_read(32'h0000_0010, 1'b0, 0);
        do_read(32'h0000_0018, 1'b0, 0);

        do_write(32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        do_write(32'h0000_0024, 32'hFFFF_FFFF, 4'b0000);
        do_read(32'h0000_0020, 1'b0, 0);

        do_write(32'h0000_4000, 32'hDEAD_BEEF, 4'hF);
        do_read(32'h0000_0000, 1'b0, 0);

        do_read(32'h0000_0010, 1'b0, 2);
        do_read(32'h0000_0014, 1'b0, 0);

        do_read(32'h0000_0030, 1'b1, 0);
        do_read(32'h0000_003C, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
